// File: rtl/shift_deser_pkg.sv
// shift_deser_pkg: shared state encoding for the serial word link (receive and transmit sides)
package shift_deser_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/shift_deser_sipo.sv
// sipo_core: LSB-first shift register and bit counter for one WIDTH-bit word
//  clk, areset : rising-edge clock, async active-high reset
//  drop        : abandon partial word, counter to 0
//  load        : accept sdata as the next bit
//  restart     : accepted bit is bit 0 of a new word
//  sdata       : serial bit
//  word        : word as it would stand after accepting sdata
//  done        : accepted bit completes a word
//  cnt         : bits collected in current word
module sipo_core #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             drop,
  input  logic             load,
  input  logic             restart,
  input  logic             sdata,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] next_cnt;
  // Only the upper WIDTH-1 bits of the shift register are ever read back; the
  // bit that would sit in position 0 is replaced by the incoming word on completion.
  generate
    if (WIDTH == 1) begin : g_one
      assign word = sdata;
    end else begin : g_many
      logic [WIDTH-2:0] shreg;
      assign word = {sdata, shreg};
      always_ff @(posedge clk or posedge areset)
        if (areset) shreg <= '0;
        else if (load) shreg <= word[WIDTH-1:1];
    end
  endgenerate
  always_comb next_cnt = restart ? CNT_W'(1) : cnt + 1'b1;
  assign done = load && next_cnt == CNT_W'(WIDTH);
  always_ff @(posedge clk or posedge areset)
    if (areset) cnt <= '0;
    else cnt <= drop ? '0 : !load ? cnt : done ? '0 : next_cnt;
endmodule

// File: rtl/shift_deser.sv
// shift_deser: serial-in/parallel-out receiver, LSB first, sof-aligned, valid/ready output
//  clk, areset        : rising-edge clock, async active-high reset
//  clear              : sync abort of partial word (output reg and flags kept)
//  ena, sdata, sof    : bit strobe, serial bit, start-of-frame qualifier
//  out_data/valid/ready : word output handshake
//  busy, bit_cnt      : partial word status
//  overrun, frame_err : sticky errors, cleared by clr_err
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             clear,
  input  logic             ena,
  input  logic             sdata,
  input  logic             sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);
  state_t           state, state_nx;
  logic             accept, done, ld, lost, resync;
  logic [WIDTH-1:0] word;
  sipo_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .areset (areset),
    .drop   (clear),
    .load   (accept),
    .restart(sof),
    .sdata  (sdata),
    .word   (word),
    .done   (done),
    .cnt    (bit_cnt)
  );
  always_comb begin
    accept   = !clear && ena && (sof || state == ST_SHIFT);
    resync   = accept && sof && state == ST_SHIFT;
    ld       = done && (!out_valid || out_ready);
    lost     = done && out_valid && !out_ready;
    state_nx = clear ? ST_IDLE : !accept ? state : done ? ST_IDLE : ST_SHIFT;
  end
  assign busy = state == ST_SHIFT;
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      state     <= ST_IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      out_data  <= ld ? word : out_data;
      out_valid <= ld || (out_valid && !out_ready);
      // A new error in the same cycle as clr_err keeps the flag set.
      overrun   <= lost || (overrun && !clr_err);
      frame_err <= resync || (frame_err && !clr_err);
    end
endmodule

// File: tb/tb_shift_deser.sv
// tb_shift_deser: table-driven check of shift_deser (WIDTH=4) plus async reset sequences
module tb_shift_deser;
  logic       clk = 1'b0;
  logic       areset, clear, ena, sdata, sof, out_ready, clr_err;
  logic [3:0] out_data;
  logic       out_valid, busy, overrun, frame_err;
  logic [2:0] bit_cnt;
  int         checks = 0;
  int         fails = 0;
  typedef struct {
    string      name;
    logic       cl, e, sd, sf, rd, ce;
    logic [10:0] exp;
  } vec_t;
  vec_t vecs[$];

  shift_deser #(.WIDTH(4)) dut (
    .clk      (clk),
    .areset   (areset),
    .clear    (clear),
    .ena      (ena),
    .sdata    (sdata),
    .sof      (sof),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .bit_cnt  (bit_cnt),
    .overrun  (overrun),
    .frame_err(frame_err),
    .clr_err  (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t v(string n, bit cl, bit e, bit sd, bit sf, bit rd, bit ce,
                             bit vl, bit [3:0] d, bit bz, bit [2:0] c, bit ov, bit fe);
    vec_t r;
    r.name = n; r.cl = cl; r.e = e; r.sd = sd; r.sf = sf; r.rd = rd; r.ce = ce;
    r.exp = {vl, d, bz, c, ov, fe};
    return r;
  endfunction

  function automatic logic [10:0] obs();
    return {out_valid, out_data, busy, bit_cnt, overrun, frame_err};
  endfunction

  task automatic check(string n, logic [10:0] got, logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got v=%b d=%h busy=%b cnt=%0d ovr=%b ferr=%b, want v=%b d=%h busy=%b cnt=%0d ovr=%b ferr=%b",
               n, got[10], got[9:6], got[5], got[4:2], got[1], got[0],
               exp[10], exp[9:6], exp[5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic step(bit cl, bit e, bit sd, bit sf, bit rd, bit ce);
    clear = cl; ena = e; sdata = sd; sof = sf; out_ready = rd; clr_err = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", n, got, exp);
    end
  endtask

  initial begin
    int nvalid;
    logic [3:0] last;
    areset = 1'b1; clear = 0; ena = 0; sdata = 0; sof = 0; out_ready = 0; clr_err = 0;
    #1;
    check("reset_async", obs(), 11'd0);
    @(posedge clk); #1;
    check("reset_held", obs(), 11'd0);
    areset = 1'b0;
    // word 4'hD, ena every cycle
    vecs.push_back(v("d_b0",   0,1,1,1,1,0, 0,4'h0,1,1,0,0));
    vecs.push_back(v("d_b1",   0,1,0,0,1,0, 0,4'h0,1,2,0,0));
    vecs.push_back(v("d_b2",   0,1,1,0,1,0, 0,4'h0,1,3,0,0));
    vecs.push_back(v("d_b3",   0,1,1,0,1,0, 1,4'hD,0,0,0,0));
    vecs.push_back(v("d_drn",  0,0,0,0,1,0, 0,4'hD,0,0,0,0));
    vecs.push_back(v("idle_nosof", 0,1,1,0,1,0, 0,4'hD,0,0,0,0));
    // word 4'h2, gapped strobe
    vecs.push_back(v("g_b0",   0,1,0,1,1,0, 0,4'hD,1,1,0,0));
    vecs.push_back(v("g_gap",  0,0,1,0,1,0, 0,4'hD,1,1,0,0));
    vecs.push_back(v("g_gapsof", 0,0,1,1,1,0, 0,4'hD,1,1,0,0));
    vecs.push_back(v("g_b1",   0,1,1,0,1,0, 0,4'hD,1,2,0,0));
    vecs.push_back(v("g_gap",  0,0,0,0,1,0, 0,4'hD,1,2,0,0));
    vecs.push_back(v("g_gap",  0,0,1,0,1,0, 0,4'hD,1,2,0,0));
    vecs.push_back(v("g_b2",   0,1,0,0,1,0, 0,4'hD,1,3,0,0));
    vecs.push_back(v("g_gap",  0,0,1,0,1,0, 0,4'hD,1,3,0,0));
    vecs.push_back(v("g_gap",  0,0,1,0,1,0, 0,4'hD,1,3,0,0));
    vecs.push_back(v("g_b3",   0,1,0,0,1,0, 1,4'h2,0,0,0,0));
    vecs.push_back(v("g_drn",  0,0,0,0,1,0, 0,4'h2,0,0,0,0));
    // 4'hA then 4'h5 with out_ready=0 -> overrun
    vecs.push_back(v("a_b0",   0,1,0,1,0,0, 0,4'h2,1,1,0,0));
    vecs.push_back(v("a_b1",   0,1,1,0,0,0, 0,4'h2,1,2,0,0));
    vecs.push_back(v("a_b2",   0,1,0,0,0,0, 0,4'h2,1,3,0,0));
    vecs.push_back(v("a_b3",   0,1,1,0,0,0, 1,4'hA,0,0,0,0));
    vecs.push_back(v("f_b0",   0,1,1,1,0,0, 1,4'hA,1,1,0,0));
    vecs.push_back(v("f_b1",   0,1,0,0,0,0, 1,4'hA,1,2,0,0));
    vecs.push_back(v("f_b2",   0,1,1,0,0,0, 1,4'hA,1,3,0,0));
    vecs.push_back(v("f_b3",   0,1,0,0,0,0, 1,4'hA,0,0,1,0));
    vecs.push_back(v("ov_hold",0,0,0,0,0,0, 1,4'hA,0,0,1,0));
    vecs.push_back(v("ov_clr", 0,0,0,0,1,1, 0,4'hA,0,0,0,0));
    // resync mid-word -> frame_err, 4'hF
    vecs.push_back(v("fe_b0",  0,1,1,1,1,0, 0,4'hA,1,1,0,0));
    vecs.push_back(v("fe_b1",  0,1,0,0,1,0, 0,4'hA,1,2,0,0));
    vecs.push_back(v("fe_sof", 0,1,1,1,1,0, 0,4'hA,1,1,0,1));
    vecs.push_back(v("fe_n1",  0,1,1,0,1,0, 0,4'hA,1,2,0,1));
    vecs.push_back(v("fe_n2",  0,1,1,0,1,0, 0,4'hA,1,3,0,1));
    vecs.push_back(v("fe_n3",  0,1,1,0,1,0, 1,4'hF,0,0,0,1));
    vecs.push_back(v("fe_drn", 0,0,0,0,1,0, 0,4'hF,0,0,0,1));
    // clr_err racing a new resync: set wins; then 4'h6
    vecs.push_back(v("se_b0",  0,1,0,1,1,0, 0,4'hF,1,1,0,1));
    vecs.push_back(v("se_race",0,1,0,1,1,1, 0,4'hF,1,1,0,1));
    vecs.push_back(v("se_ce",  0,0,0,0,1,1, 0,4'hF,1,1,0,0));
    vecs.push_back(v("se_b1",  0,1,1,0,1,0, 0,4'hF,1,2,0,0));
    vecs.push_back(v("se_b2",  0,1,1,0,1,0, 0,4'hF,1,3,0,0));
    vecs.push_back(v("se_b3",  0,1,0,0,1,0, 1,4'h6,0,0,0,0));
    vecs.push_back(v("se_drn", 0,0,0,0,1,0, 0,4'h6,0,0,0,0));
    // 4'h3 held, 4'hC completes on the draining edge
    vecs.push_back(v("h_b0",   0,1,1,1,0,0, 0,4'h6,1,1,0,0));
    vecs.push_back(v("h_b1",   0,1,1,0,0,0, 0,4'h6,1,2,0,0));
    vecs.push_back(v("h_b2",   0,1,0,0,0,0, 0,4'h6,1,3,0,0));
    vecs.push_back(v("h_b3",   0,1,0,0,0,0, 1,4'h3,0,0,0,0));
    vecs.push_back(v("c_b0",   0,1,0,1,0,0, 1,4'h3,1,1,0,0));
    vecs.push_back(v("c_b1",   0,1,0,0,0,0, 1,4'h3,1,2,0,0));
    vecs.push_back(v("c_b2",   0,1,1,0,0,0, 1,4'h3,1,3,0,0));
    vecs.push_back(v("c_b3",   0,1,1,0,1,0, 1,4'hC,0,0,0,0));
    vecs.push_back(v("c_drn",  0,0,0,0,1,0, 0,4'hC,0,0,0,0));
    // clear mid-word, then 4'h9; clear leaves output reg alone
    vecs.push_back(v("k_b0",   0,1,1,1,1,0, 0,4'hC,1,1,0,0));
    vecs.push_back(v("k_b1",   0,1,1,0,1,0, 0,4'hC,1,2,0,0));
    vecs.push_back(v("k_clr",  1,1,1,1,1,0, 0,4'hC,0,0,0,0));
    vecs.push_back(v("k_idle", 0,1,0,0,1,0, 0,4'hC,0,0,0,0));
    vecs.push_back(v("n_b0",   0,1,1,1,0,0, 0,4'hC,1,1,0,0));
    vecs.push_back(v("n_b1",   0,1,0,0,0,0, 0,4'hC,1,2,0,0));
    vecs.push_back(v("n_b2",   0,1,0,0,0,0, 0,4'hC,1,3,0,0));
    vecs.push_back(v("n_b3",   0,1,1,0,0,0, 1,4'h9,0,0,0,0));
    vecs.push_back(v("k_clr2", 1,0,0,0,0,0, 1,4'h9,0,0,0,0));
    vecs.push_back(v("n_drn",  0,0,0,0,1,0, 0,4'h9,0,0,0,0));
    foreach (vecs[i]) begin
      step(vecs[i].cl, vecs[i].e, vecs[i].sd, vecs[i].sf, vecs[i].rd, vecs[i].ce);
      check(vecs[i].name, obs(), vecs[i].exp);
    end
    // areset after 3 bits, then clean 4'h9: only 4'h9 delivered
    step(0,1,1,1,1,0);
    step(0,1,0,0,1,0);
    step(0,1,1,0,1,0);
    #2 areset = 1'b1;
    #1 check("ar_mid", obs(), 11'd0);
    @(posedge clk); #1 areset = 1'b0;
    nvalid = 0; last = 4'h0;
    step(0,1,1,1,1,0);
    step(0,1,0,0,1,0);
    step(0,1,0,0,1,0);
    step(0,1,1,0,1,0);
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin nvalid++; last = out_data; end
      step(0,0,0,0,1,0);
    end
    chk1("ar_count", nvalid, 1);
    chk1("ar_word", last, 4'h9);
    // areset while out_valid=1 with flags set
    step(0,1,0,1,0,0); step(0,1,1,0,0,0); step(0,1,1,0,0,0); step(0,1,1,0,0,0);
    step(0,1,1,1,0,0);
    step(0,1,0,1,0,0);
    check("ar_pre", obs(), {1'b1, 4'hE, 1'b1, 3'd1, 1'b0, 1'b1});
    #2 areset = 1'b1;
    #1 check("ar_valid", obs(), 11'd0);
    @(posedge clk); #1 areset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
